// File: rtl/code_pkg.sv
// Shared definitions for the 4b/5b code path: code width, serial FSM states and frame length.
// Optional parity bit is enabled by defining CODE_TX_PARITY_EN.
package code_pkg;

  localparam int DATA_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef CODE_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int frame_bits();
`ifdef CODE_TX_PARITY_EN
    return DATA_W + 3;
`else
    return DATA_W + 2;
`endif
  endfunction

endpackage

// File: rtl/code_frame_tx_if.sv
// Valid/ready code handshake between the 4b/5b converter (master) and the frame transmitter (slave).
interface code_frame_tx_if #(
  parameter int DATA_W = code_pkg::DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_code;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/code_fifo.sv
// Synchronous FIFO buffering converted codes ahead of the serialiser; head is visible combinationally.
module code_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic              full_s;
  logic              empty_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == CNT_W'(0));
  // A push while full is dropped; there is no pass-through of a simultaneous pop.
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/code_frame_tx.sv
// Serial frame transmitter for 5-bit codes: FIFO, then start / data LSB-first / stop on tx.
// Define CODE_TX_PARITY_EN to insert an even-parity bit between data and stop.
module code_frame_tx #(
  parameter int DATA_W       = code_pkg::DATA_W,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  code_frame_tx_if.slave         in_if,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import code_pkg::*;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  tx_state_t         state_r;
  tx_state_t         state_nxt_s;
  logic [BAUD_W-1:0] baud_r;
  logic [BAUD_W-1:0] baud_nxt_s;
  logic [BIT_W-1:0]  bit_r;
  logic [BIT_W-1:0]  bit_nxt_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_nxt_s;
  logic              tx_nxt_s;
  logic              tx_r;
  logic              busy_r;
  logic              pop_s;
  logic              bit_end_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] head_s;
`ifdef CODE_TX_PARITY_EN
  logic              par_r;
  logic              par_nxt_s;

  function automatic logic even_parity(input logic [DATA_W-1:0] code);
    return ^code;
  endfunction
`endif

  code_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_if.in_valid),
    .wdata (in_if.in_code),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign in_if.in_ready = ~fifo_full_s;
  assign bit_end_s      = (baud_r == BAUD_LAST);
  assign tx             = tx_r;
  assign busy           = busy_r;

  // Next-state, counters and FIFO pop; loading a new code always restarts both counters.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    pop_s       = 1'b0;
`ifdef CODE_TX_PARITY_EN
    par_nxt_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = head_s;
`ifdef CODE_TX_PARITY_EN
          par_nxt_s   = even_parity(head_s);
`endif
          baud_nxt_s  = '0;
          bit_nxt_s   = '0;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_nxt_s  = '0;
          state_nxt_s = ST_DATA;
        end else begin
          baud_nxt_s  = baud_r + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_nxt_s  = '0;
          shift_nxt_s = shift_r >> 1;
          if (bit_r == BIT_LAST) begin
            bit_nxt_s   = '0;
`ifdef CODE_TX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            bit_nxt_s   = bit_r + BIT_W'(1);
          end
        end else begin
          baud_nxt_s  = baud_r + BAUD_W'(1);
        end
      end
`ifdef CODE_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          baud_nxt_s  = '0;
          state_nxt_s = ST_STOP;
        end else begin
          baud_nxt_s  = baud_r + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          baud_nxt_s = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            shift_nxt_s = head_s;
`ifdef CODE_TX_PARITY_EN
            par_nxt_s   = even_parity(head_s);
`endif
            bit_nxt_s   = '0;
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          baud_nxt_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        baud_nxt_s  = '0;
        bit_nxt_s   = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the upcoming state, so tx can be registered without a cycle of lag.
  always_comb begin
    tx_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef CODE_TX_PARITY_EN
      ST_PARITY: tx_nxt_s = par_nxt_s;
`endif
      default:   tx_nxt_s = 1'b1;
    endcase
  end

  // FSM, counters, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      baud_r  <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
`ifdef CODE_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
`ifdef CODE_TX_PARITY_EN
      par_r   <= par_nxt_s;
`endif
    end
  end

endmodule
